// File: rtl/uart_echo_buffer.sv
// Byte-stream buffer between the USB UART output and input pipelines.
// FIFO with pass/uppercase/line/drop echo modes and a saturating drop counter.
module uart_echo_buffer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  EOL        = 8'h0D
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           drop_cnt,
  output logic [1:0]            active_mode
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  localparam logic [1:0] MODE_UPPER = 2'b01;
  localparam logic [1:0] MODE_LINE  = 2'b10;
  localparam logic [1:0] MODE_DROP  = 2'b11;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] wdata;
  logic              full, empty, wr_acc, rd_acc, store;

  assign full      = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign in_ready  = reset_n && ((mode_q == MODE_DROP) || !full);
  assign out_valid = (rd_ptr_q != cm_ptr_q);
  assign out_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready;
  assign store     = wr_acc && (mode_q != MODE_DROP);

  assign level       = level_q;
  assign drop_cnt    = drop_cnt_q;
  assign active_mode = mode_q;

  // Next-state for pointers, commit point, counter and mode.
  always_comb begin
    wdata      = in_data;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    drop_cnt_d = drop_cnt_q;
    mode_d     = mode_q;

    if ((mode_q == MODE_UPPER) && (in_data[7:0] >= 8'h61) && (in_data[7:0] <= 8'h7A)) begin
      wdata[7:0] = in_data[7:0] - 8'h20;
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Line mode commits on EOL, or when the FIFO fills so a long line cannot deadlock.
    if (store) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if ((mode_q != MODE_LINE) || (in_data == DATA_W'(EOL)) ||
          ((wr_ptr_d - rd_ptr_d) == PTR_W'(DEPTH))) begin
        cm_ptr_d = wr_ptr_d;
      end
    end

    if (wr_acc && (mode_q == MODE_DROP) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (empty && !wr_acc) begin
      mode_d = mode;
    end

    level_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      mode_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      mode_q     <= mode_d;
    end
  end

  // Storage array needs no reset; contents are only visible behind the commit pointer.
  always_ff @(posedge clk_48mhz) begin
    if (store) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

endmodule
